divmod_sequencer: RTL and testbench
===================================

Name: divmod_sequencer

Overview:
- Shared iterative divide/modulo unit. Two requesters contend for one restoring-division datapath.
- A round-robin arbiter grants one request at a time. An FSM then runs the divide over WIDTH cycles, applies sign correction and holds the result until the consumer accepts it.
- Results match Verilog `/` and `%` semantics: truncate toward zero, remainder takes the sign of the dividend.
- Divide-by-zero and signed overflow produce defined values, never X.

Parameters:
- WIDTH, 8, operand/quotient/remainder width in bits (≥2).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid_0  in  1  requester 0 has an operation pending.
- req_ready_0  out  1  requester 0 operation accepted this cycle.
- req_a_0  in  WIDTH  requester 0 dividend.
- req_b_0  in  WIDTH  requester 0 divisor.
- req_signed_0  in  1  1 = two's-complement operands, 0 = unsigned.
- req_valid_1, req_ready_1, req_a_1, req_b_1, req_signed_1: same as above, for requester 1.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes the result.
- resp_id  out  1  requester whose operation this result belongs to.
- resp_quot  out  WIDTH  quotient.
- resp_rem  out  WIDTH  remainder.
- resp_dbz  out  1  divisor was zero.
- resp_ovf  out  1  signed overflow (most-negative / -1).

Behaviour:
- Reset values:
  - All outputs are 0.
  - FSM goes to IDLE.
  - last_grant = 1, so requester 0 wins the first tie.
  - Iteration counter is 0.
- States: IDLE, ITER, FIX, DONE.
- IDLE:
  - req_ready_i = (state==IDLE) && grant==i. This is combinational from registered state and the current valids.
  - Grant rule:
    - If only one requester is valid, that one is granted.
    - If both are valid, the one ≠ last_grant is granted.
  - On the accepting edge:
    - Latch id, signed flag, and the sign bits of a and b.
    - Latch |a| and |b|. Absolute values are taken only when signed=1.
    - Clear the partial remainder. Set counter = 0.
    - Update last_grant. Go to ITER.
- ITER: one restoring step per edge.
  - Shift the partial remainder left, bringing in the next dividend MSB.
  - Trial-subtract the divisor. Keep the difference only if it is non-negative, and shift the quotient bit in.
  - After WIDTH steps, go to FIX.
  - Internal remainder path is WIDTH+1 bits.
- FIX (one edge):
  - Signed mode:
    - Negate the quotient if sign_a XOR sign_b.
    - Negate the remainder if sign_a.
  - Register the results into the resp_* outputs.
  - Go to DONE.
- DONE:
  - resp_valid = 1.
  - All resp_* outputs stay stable while resp_ready = 0.
  - On resp_valid && resp_ready: resp_valid goes to 0 on that edge and the FSM returns to IDLE. The next request can be accepted on the following edge.
- Latency:
  - resp_valid rises exactly WIDTH+1 edges after the accepting edge (9 for WIDTH=8).
  - Latency is constant for all operands, including divide-by-zero.
- Throughput: at most one operation in flight. Both req_ready outputs are low outside IDLE.
- Divide-by-zero (b==0), both modes:
  - quot = all ones (-1 in signed mode).
  - rem = dividend, unmodified.
  - dbz = 1.
- Signed overflow (a = -2^(WIDTH-1), b = -1):
  - quot = -2^(WIDTH-1).
  - rem = 0.
  - ovf = 1.
- Operand magnitude -2^(WIDTH-1) must be handled as an unsigned magnitude 2^(WIDTH-1), with no truncation.
- Requester rules:
  - Requesters must hold valid and operands stable until ready.
  - Deasserting valid before ready is legal. The request is simply not taken.
- Reset mid-operation, in any state:
  - Abandon the operation. resp_valid = 0 on the next edge.
  - No response is ever issued for the abandoned operation.
- dbz and ovf are never both 1.

Test Plan:
1. Unsigned 15 / 4 on port 0, resp_ready held 1: resp_quot=3, resp_rem=3, resp_id=0, resp_dbz=0, resp_valid exactly 9 edges after accept.
2. Signed operations, issued back-to-back on port 1:
   - -15/4 → quot=-3 (0xFD), rem=-3 (0xFD).
   - -15/-4 → quot=3, rem=-3.
   - 15/-4 → quot=-3, rem=3.
3. Signed boundaries:
   - -128 / -1 → quot=0x80, rem=0, ovf=1.
   - -128 / 3 → quot=-42 (0xD6), rem=-2 (0xFE).
4. Divide-by-zero:
   - Unsigned 200/0 → quot=0xFF, rem=0xC8, dbz=1.
   - Signed -7/0 → quot=0xFF, rem=0xF9, dbz=1.
   - Latency is still 9 in both cases.
5. Both requesters valid continuously, resp_ready toggling 0/1:
   - Grants alternate 0,1,0,1 starting with 0.
   - Outputs are stable while resp_ready=0.
   - No request is accepted while resp_valid=1.
6. rst pulsed during ITER (step 4):
   - Next edge: resp_valid=0, both req_ready reflect IDLE arbitration with last_grant=1.
   - A subsequent 100/7 returns quot=14, rem=2 with no stale response issued.

Source files
------------

// File: rtl/divmod_sequencer.sv
// divmod_sequencer: shared restoring divide/modulo unit arbitrated round-robin between two requesters.
// Latency: resp_valid rises WIDTH+1 edges after the accepting edge, independent of operands.
// Backpressure: one operation in flight; req_ready_* low outside IDLE, results held until resp_ready.
// Ports: clk/rst (sync, active-high); req_{valid,ready,a,b,signed}_{0,1} request side;
//        resp_{valid,ready,id,quot,rem,dbz,ovf} response side.
module divmod_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_0,
  output logic             req_ready_0,
  input  logic [WIDTH-1:0] req_a_0,
  input  logic [WIDTH-1:0] req_b_0,
  input  logic             req_signed_0,
  input  logic             req_valid_1,
  output logic             req_ready_1,
  input  logic [WIDTH-1:0] req_a_1,
  input  logic [WIDTH-1:0] req_b_1,
  input  logic             req_signed_1,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_quot,
  output logic [WIDTH-1:0] resp_rem,
  output logic             resp_dbz,
  output logic             resp_ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             id_q, id_d;
  logic             sgn_q, sgn_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             op_dbz_q, op_dbz_d;
  logic             op_ovf_q, op_ovf_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend magnitude, shifted out MSB-first; quotient shifts in
  logic [WIDTH-1:0] dvs_q, dvs_d;   // divisor magnitude
  logic [WIDTH:0]   rem_q, rem_d;   // partial remainder, one bit wider than operands
  logic             resp_valid_q, resp_valid_d;
  logic             resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_quot_q, resp_quot_d;
  logic [WIDTH-1:0] resp_rem_q, resp_rem_d;
  logic             resp_dbz_q, resp_dbz_d;
  logic             resp_ovf_q, resp_ovf_d;

  // Arbitration and operand selection
  logic             grant;
  logic             any_req;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             sel_sgn, sel_sa, sel_sb;

  // Restoring step
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH+1:0] trial;

  // Sign correction
  logic [WIDTH-1:0] quot_fix, rem_fix;

  always_comb begin
    any_req = req_valid_0 | req_valid_1;
    // Tie goes to whichever requester was not served last.
    grant   = (req_valid_0 && req_valid_1) ? ~last_grant_q : req_valid_1;
    sel_a   = grant ? req_a_1 : req_a_0;
    sel_b   = grant ? req_b_1 : req_b_0;
    sel_sgn = grant ? req_signed_1 : req_signed_0;
    sel_sa  = sel_sgn & sel_a[WIDTH-1];
    sel_sb  = sel_sgn & sel_b[WIDTH-1];
    req_ready_0 = (state_q == IDLE) && req_valid_0 && !grant;
    req_ready_1 = (state_q == IDLE) && req_valid_1 && grant;

    rem_shift = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    trial     = {1'b0, rem_shift} - {2'b00, dvs_q};

    quot_fix  = (sgn_q && (sa_q ^ sb_q)) ? ('0 - dvd_q) : dvd_q;
    rem_fix   = (sgn_q && sa_q) ? ('0 - rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    id_d         = id_q;
    sgn_d        = sgn_q;
    sa_d         = sa_q;
    sb_d         = sb_q;
    op_dbz_d     = op_dbz_q;
    op_ovf_d     = op_ovf_q;
    dvd_d        = dvd_q;
    dvs_d        = dvs_q;
    rem_d        = rem_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_quot_d  = resp_quot_q;
    resp_rem_d   = resp_rem_q;
    resp_dbz_d   = resp_dbz_q;
    resp_ovf_d   = resp_ovf_q;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          id_d         = grant;
          last_grant_d = grant;
          sgn_d        = sel_sgn;
          sa_d         = sel_sa;
          sb_d         = sel_sb;
          // Negating the most-negative value wraps to itself, which is the
          // correct unsigned magnitude 2^(WIDTH-1).
          dvd_d        = sel_sa ? ('0 - sel_a) : sel_a;
          dvs_d        = sel_sb ? ('0 - sel_b) : sel_b;
          op_dbz_d     = (sel_b == '0);
          op_ovf_d     = sel_sgn && (sel_a == {1'b1, {(WIDTH-1){1'b0}}}) && (sel_b == '1);
          rem_d        = '0;
          cnt_d        = '0;
          state_d      = ITER;
        end
      end
      ITER: begin
        if (!trial[WIDTH+1]) begin
          rem_d = trial[WIDTH:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_shift;
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        // With a zero divisor every trial subtract succeeds, so the remainder
        // is already the dividend magnitude; only the quotient needs forcing.
        resp_quot_d  = op_dbz_q ? '1 : quot_fix;
        resp_rem_d   = rem_fix;
        resp_id_d    = id_q;
        resp_dbz_d   = op_dbz_q;
        resp_ovf_d   = op_ovf_q;
        resp_valid_d = 1'b1;
        state_d      = DONE;
      end
      DONE: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      id_q         <= 1'b0;
      sgn_q        <= 1'b0;
      sa_q         <= 1'b0;
      sb_q         <= 1'b0;
      op_dbz_q     <= 1'b0;
      op_ovf_q     <= 1'b0;
      dvd_q        <= '0;
      dvs_q        <= '0;
      rem_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_quot_q  <= '0;
      resp_rem_q   <= '0;
      resp_dbz_q   <= 1'b0;
      resp_ovf_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      id_q         <= id_d;
      sgn_q        <= sgn_d;
      sa_q         <= sa_d;
      sb_q         <= sb_d;
      op_dbz_q     <= op_dbz_d;
      op_ovf_q     <= op_ovf_d;
      dvd_q        <= dvd_d;
      dvs_q        <= dvs_d;
      rem_q        <= rem_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_quot_q  <= resp_quot_d;
      resp_rem_q   <= resp_rem_d;
      resp_dbz_q   <= resp_dbz_d;
      resp_ovf_q   <= resp_ovf_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_quot  = resp_quot_q;
  assign resp_rem   = resp_rem_q;
  assign resp_dbz   = resp_dbz_q;
  assign resp_ovf   = resp_ovf_q;

endmodule

// File: tb/tb_divmod_sequencer.sv
// Bench for divmod_sequencer: directed operations with hand-computed results,
// scoreboard queue checked by an independent response monitor.
module tb_divmod_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid_0, req_ready_0, req_signed_0;
  logic [7:0] req_a_0, req_b_0;
  logic       req_valid_1, req_ready_1, req_signed_1;
  logic [7:0] req_a_1, req_b_1;
  logic       resp_valid, resp_ready, resp_id, resp_dbz, resp_ovf;
  logic [7:0] resp_quot, resp_rem;

  typedef struct packed {
    logic       id;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    logic       ovf;
  } exp_t;

  exp_t sb_q[$];
  int   acc_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   toggle = 1'b0;

  divmod_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_a_0(req_a_0),
    .req_b_0(req_b_0), .req_signed_0(req_signed_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_a_1(req_a_1),
    .req_b_1(req_b_1), .req_signed_1(req_signed_1),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_quot(resp_quot), .resp_rem(resp_rem), .resp_dbz(resp_dbz), .resp_ovf(resp_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=none required=event", name);
  endtask

  // resp_ready driver: held high, or toggled every cycle when requested
  initial begin
    resp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      resp_ready = toggle ? !resp_ready : 1'b1;
    end
  end

  // Monitor: latency, hold-while-stalled, no accept during DONE, scoreboard compare
  exp_t got, prev_got;
  bit   prev_valid = 1'b0, prev_ready = 1'b0;
  always @(negedge clk) begin
    got = {resp_id, resp_quot, resp_rem, resp_dbz, resp_ovf};
    if (rst) begin
      acc_q.delete();
      prev_valid = 1'b0;
    end else begin
      if ((req_valid_0 && req_ready_0) || (req_valid_1 && req_ready_1))
        acc_q.push_back(cyc + 1);
      if (resp_valid)
        check("no_accept_while_valid", {30'd0, req_ready_0, req_ready_1}, 32'd0);
      if (resp_valid && !prev_valid) begin
        if (acc_q.size() == 0) fail("latency_no_accept");
        else check("latency", cyc - acc_q.pop_front(), 32'd9);
      end
      if (prev_valid && !prev_ready)
        check("hold_stable", {resp_valid, got}, {1'b1, prev_got});
      if (resp_valid && resp_ready) begin
        if (sb_q.size() == 0) fail("unexpected_response");
        else check("resp", got, sb_q.pop_front());
      end
      prev_valid = resp_valid;
    end
    prev_ready = resp_ready;
    prev_got   = got;
  end

  task automatic issue(input bit port, input logic [7:0] a, input logic [7:0] b, input bit sg,
                       input logic [7:0] eq, input logic [7:0] er, input bit ed, input bit eo);
    bit ok;
    sb_q.push_back({port, eq, er, ed, eo});
    @(posedge clk);
    #1;
    if (port) begin
      req_a_1 = a; req_b_1 = b; req_signed_1 = sg; req_valid_1 = 1'b1;
    end else begin
      req_a_0 = a; req_b_0 = b; req_signed_0 = sg; req_valid_0 = 1'b1;
    end
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (port ? req_ready_1 : req_ready_0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("accept_timeout");
    @(posedge clk);
    #1;
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !resp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("drain_timeout");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit ok;
    rst = 1'b1;
    req_valid_0 = 0; req_a_0 = 0; req_b_0 = 0; req_signed_0 = 0;
    req_valid_1 = 0; req_a_1 = 0; req_b_1 = 0; req_signed_1 = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_valid", resp_valid, 0);
    check("reset_quot", resp_quot, 0);
    check("reset_rem", resp_rem, 0);
    check("reset_flags", {resp_id, resp_dbz, resp_ovf}, 0);
    check("reset_ready", {req_ready_0, req_ready_1}, 0);

    // 1: unsigned 15/4
    issue(0, 8'd15, 8'd4, 0, 8'd3, 8'd3, 0, 0);
    drain();
    // 2: signed back-to-back on port 1
    issue(1, 8'hF1, 8'd4,  1, 8'hFD, 8'hFD, 0, 0);
    issue(1, 8'hF1, 8'hFC, 1, 8'd3,  8'hFD, 0, 0);
    issue(1, 8'd15, 8'hFC, 1, 8'hFD, 8'd3,  0, 0);
    drain();
    // 3: signed boundaries
    issue(0, 8'h80, 8'hFF, 1, 8'h80, 8'h00, 0, 1);
    issue(0, 8'h80, 8'd3,  1, 8'hD6, 8'hFE, 0, 0);
    drain();
    // 4: divide by zero (last op on port 1 so the next tie goes to port 0)
    issue(1, 8'd200, 8'd0, 0, 8'hFF, 8'hC8, 1, 0);
    issue(1, 8'hF9,  8'd0, 1, 8'hFF, 8'hF9, 1, 0);
    drain();

    // 5: both requesters valid, resp_ready toggling: grants 0,1,0,1
    sb_q.push_back({1'b0, 8'd8,  8'd2,  1'b0, 1'b0});
    sb_q.push_back({1'b1, 8'hF8, 8'hFE, 1'b0, 1'b0});
    sb_q.push_back({1'b0, 8'd8,  8'd2,  1'b0, 1'b0});
    sb_q.push_back({1'b1, 8'hF8, 8'hFE, 1'b0, 1'b0});
    toggle = 1'b1;
    @(posedge clk);
    #1;
    req_a_0 = 8'd50;  req_b_0 = 8'd6; req_signed_0 = 0; req_valid_0 = 1;
    req_a_1 = 8'hCE;  req_b_1 = 8'd6; req_signed_1 = 1; req_valid_1 = 1;
    cnt = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if ((req_valid_0 && req_ready_0) || (req_valid_1 && req_ready_1)) cnt++;
      if (cnt == 4) break;
    end
    check("arb_accept_count", cnt, 4);
    @(posedge clk);
    #1;
    req_valid_0 = 0;
    req_valid_1 = 0;
    drain();
    toggle = 1'b0;

    // 6: reset during ITER abandons the operation
    @(posedge clk);
    #1;
    req_a_0 = 8'd77; req_b_0 = 8'd5; req_signed_0 = 0; req_valid_0 = 1;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (req_ready_0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("abandon_accept_timeout");
    @(posedge clk);
    #1 req_valid_0 = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    req_a_0 = 8'd100; req_b_0 = 8'd7; req_signed_0 = 0; req_valid_0 = 1;
    req_a_1 = 8'd9;   req_b_1 = 8'd3; req_signed_1 = 0; req_valid_1 = 1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb_q.push_back({1'b0, 8'd14, 8'd2, 1'b0, 1'b0});
    @(negedge clk);
    check("rst_mid_valid", resp_valid, 0);
    check("rst_mid_arb", {req_ready_0, req_ready_1}, 2'b10);
    @(posedge clk);
    #1;
    req_valid_0 = 0;
    req_valid_1 = 0;
    drain();
    repeat (20) @(negedge clk);
    check("no_stale_response", resp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
